ascon_op_scheduler: RTL and testbench

ASCON_OP_SCHEDULER -- requirements
Module: ascon_op_scheduler

---
 rtl/ascon_op_scheduler.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_ascon_op_scheduler.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_op_scheduler.sv
// Ascon operation sequencer: steps INIT/AD/MSG/FINAL/SQUEEZE for AEAD, hash, xof and cxof,
// launching the shared permutation and pulsing the state-update strobes in between.
module ascon_op_scheduler #(
    parameter int unsigned PA_ROUNDS = 12,
    parameter int unsigned PB_ROUNDS = 6
) (
    input  logic       clk,
    input  logic       spi_rst_n,
    input  logic [2:0] operation_mode,
    input  logic       start,
    input  logic [3:0] ad_blocks,
    input  logic [3:0] msg_blocks,
    input  logic [3:0] sq_blocks,
    input  logic       perm_done,
    output logic       perm_start,
    output logic [3:0] perm_rounds,
    output logic [2:0] phase,
    output logic       key_xor_init,
    output logic       key_xor_final,
    output logic       dsep,
    output logic       sq_valid,
    output logic [3:0] blk_idx,
    output logic       busy,
    output logic       done,
    output logic       err
);
    localparam logic [3:0] RND_PA = 4'(PA_ROUNDS);
    localparam logic [3:0] RND_PB = 4'(PB_ROUNDS);

    localparam logic [2:0] PH_IDLE    = 3'd0;
    localparam logic [2:0] PH_INIT    = 3'd1;
    localparam logic [2:0] PH_AD      = 3'd2;
    localparam logic [2:0] PH_MSG     = 3'd3;
    localparam logic [2:0] PH_FINAL   = 3'd4;
    localparam logic [2:0] PH_SQUEEZE = 3'd5;
    localparam logic [2:0] PH_DONE    = 3'd6;

    localparam logic [2:0] MODE_ENC  = 3'd1;
    localparam logic [2:0] MODE_DEC  = 3'd2;
    localparam logic [2:0] MODE_HASH = 3'd3;
    localparam logic [2:0] MODE_CXOF = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE, ST_WAIT, ST_KXI, ST_DSEP, ST_KXF, ST_SQV, ST_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] mode_q, mode_d;
    logic [3:0] ad_q, ad_d, msg_q, msg_d, sq_q, sq_d;
    logic [2:0] phase_d;
    logic [3:0] blk_d, perm_rounds_d;
    logic       perm_start_d, key_xor_init_d, key_xor_final_d, dsep_d, sq_valid_d;
    logic       busy_d, done_d, err_d;

    logic       is_aead, is_cxof;
    logic [3:0] blk_nxt, ad_rounds;
    logic       issue, go_dsep, go_kxf, go_sqv, go_done;
    logic [3:0] issue_rounds, issue_blk, sqv_blk;
    logic [2:0] issue_phase;

    assign is_aead   = (mode_q == MODE_ENC) || (mode_q == MODE_DEC);
    assign is_cxof   = (mode_q == MODE_CXOF);
    assign blk_nxt   = blk_idx + 4'd1;
    assign ad_rounds = is_aead ? RND_PB : RND_PA;

    // Next-state: each step either launches a permutation or emits one strobe cycle.
    always_comb begin
        state_d         = state_q;
        mode_d          = mode_q;
        ad_d            = ad_q;
        msg_d           = msg_q;
        sq_d            = sq_q;
        phase_d         = phase;
        blk_d           = blk_idx;
        perm_rounds_d   = perm_rounds;
        busy_d          = busy;
        perm_start_d    = 1'b0;
        key_xor_init_d  = 1'b0;
        key_xor_final_d = 1'b0;
        dsep_d          = 1'b0;
        sq_valid_d      = 1'b0;
        done_d          = 1'b0;
        err_d           = 1'b0;
        issue           = 1'b0;
        issue_rounds    = RND_PA;
        issue_phase     = phase;
        issue_blk       = 4'd0;
        go_dsep         = 1'b0;
        go_kxf          = 1'b0;
        go_sqv          = 1'b0;
        go_done         = 1'b0;
        sqv_blk         = 4'd0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (operation_mode != 3'd0 && operation_mode <= MODE_CXOF) begin
                        mode_d      = operation_mode;
                        ad_d        = ad_blocks;
                        msg_d       = (msg_blocks == 4'd0) ? 4'd1 : msg_blocks;
                        sq_d        = (operation_mode == MODE_HASH) ? 4'd4 :
                                      (sq_blocks == 4'd0) ? 4'd1 : sq_blocks;
                        busy_d      = 1'b1;
                        issue       = 1'b1;
                        issue_phase = PH_INIT;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (perm_done) begin
                    unique case (phase)
                        PH_INIT: begin
                            if (is_aead) begin
                                state_d        = ST_KXI;
                                key_xor_init_d = 1'b1;
                            end else if (is_cxof && ad_q != 4'd0) begin
                                issue       = 1'b1;
                                issue_phase = PH_AD;
                            end else if (is_cxof) begin
                                go_dsep = 1'b1;
                            end else begin
                                issue       = 1'b1;
                                issue_phase = PH_MSG;
                            end
                        end
                        PH_AD: begin
                            if (blk_nxt < ad_q) begin
                                issue        = 1'b1;
                                issue_rounds = ad_rounds;
                                issue_phase  = PH_AD;
                                issue_blk    = blk_nxt;
                            end else begin
                                go_dsep = 1'b1;
                            end
                        end
                        PH_MSG: begin
                            if (is_aead) begin
                                if (blk_nxt < msg_q - 4'd1) begin
                                    issue        = 1'b1;
                                    issue_rounds = RND_PB;
                                    issue_phase  = PH_MSG;
                                    issue_blk    = blk_nxt;
                                end else begin
                                    go_kxf = 1'b1;
                                end
                            end else if (blk_nxt < msg_q) begin
                                issue       = 1'b1;
                                issue_phase = PH_MSG;
                                issue_blk   = blk_nxt;
                            end else begin
                                go_sqv = 1'b1;
                            end
                        end
                        PH_FINAL:   go_done = 1'b1;
                        PH_SQUEEZE: begin
                            go_sqv  = 1'b1;
                            sqv_blk = blk_nxt;
                        end
                        default:    go_done = 1'b1;
                    endcase
                end
            end
            ST_KXI: begin
                if (ad_q != 4'd0) begin
                    issue        = 1'b1;
                    issue_rounds = RND_PB;
                    issue_phase  = PH_AD;
                end else begin
                    go_dsep = 1'b1;
                end
            end
            ST_DSEP: begin
                if (!is_aead) begin
                    issue       = 1'b1;
                    issue_phase = PH_MSG;
                end else if (msg_q > 4'd1) begin
                    issue        = 1'b1;
                    issue_rounds = RND_PB;
                    issue_phase  = PH_MSG;
                end else begin
                    go_kxf = 1'b1;
                end
            end
            ST_KXF: begin
                issue       = 1'b1;
                issue_phase = PH_FINAL;
            end
            ST_SQV: begin
                if (blk_nxt < sq_q) begin
                    issue       = 1'b1;
                    issue_phase = PH_SQUEEZE;
                    issue_blk   = blk_idx;
                end else begin
                    go_done = 1'b1;
                end
            end
            ST_DONE: begin
                state_d       = ST_IDLE;
                phase_d       = PH_IDLE;
                blk_d         = 4'd0;
                perm_rounds_d = 4'd0;
                busy_d        = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase

        if (issue) begin
            state_d       = ST_WAIT;
            perm_start_d  = 1'b1;
            perm_rounds_d = issue_rounds;
            phase_d       = issue_phase;
            blk_d         = issue_blk;
        end
        if (go_dsep) begin
            state_d = ST_DSEP;
            dsep_d  = 1'b1;
            phase_d = PH_MSG;
            blk_d   = 4'd0;
        end
        if (go_kxf) begin
            state_d         = ST_KXF;
            key_xor_final_d = 1'b1;
            phase_d         = PH_FINAL;
            blk_d           = 4'd0;
        end
        if (go_sqv) begin
            state_d    = ST_SQV;
            sq_valid_d = 1'b1;
            phase_d    = PH_SQUEEZE;
            blk_d      = sqv_blk;
        end
        if (go_done) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            phase_d = PH_DONE;
            blk_d   = 4'd0;
        end
    end

    // State, latched request and registered outputs.
    always_ff @(posedge clk or negedge spi_rst_n) begin
        if (!spi_rst_n) begin
            state_q       <= ST_IDLE;
            mode_q        <= 3'd0;
            ad_q          <= 4'd0;
            msg_q         <= 4'd0;
            sq_q          <= 4'd0;
            phase         <= PH_IDLE;
            blk_idx       <= 4'd0;
            perm_rounds   <= 4'd0;
            perm_start    <= 1'b0;
            key_xor_init  <= 1'b0;
            key_xor_final <= 1'b0;
            dsep          <= 1'b0;
            sq_valid      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            ad_q          <= ad_d;
            msg_q         <= msg_d;
            sq_q          <= sq_d;
            phase         <= phase_d;
            blk_idx       <= blk_d;
            perm_rounds   <= perm_rounds_d;
            perm_start    <= perm_start_d;
            key_xor_init  <= key_xor_init_d;
            key_xor_final <= key_xor_final_d;
            dsep          <= dsep_d;
            sq_valid      <= sq_valid_d;
            busy          <= busy_d;
            done          <= done_d;
            err           <= err_d;
        end
    end
endmodule

// File: tb/tb_ascon_op_scheduler.sv
// Self-checking bench for ascon_op_scheduler: expected event stream per operation is queued at
// start and compared as the scheduler emits permutation launches and strobes.
module tb_ascon_op_scheduler;
    logic       clk = 1'b0;
    logic       spi_rst_n;
    logic [2:0] operation_mode;
    logic       start;
    logic [3:0] ad_blocks, msg_blocks, sq_blocks;
    logic       perm_done;
    logic       perm_start;
    logic [3:0] perm_rounds;
    logic [2:0] phase;
    logic       key_xor_init, key_xor_final, dsep, sq_valid;
    logic [3:0] blk_idx;
    logic       busy, done, err;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];

    localparam int EV_PERM = 1, EV_KXI = 2, EV_DSEP = 3, EV_KXF = 4, EV_SQV = 5, EV_DONE = 6;

    ascon_op_scheduler #(.PA_ROUNDS(12), .PB_ROUNDS(6)) dut (
        .clk(clk), .spi_rst_n(spi_rst_n), .operation_mode(operation_mode), .start(start),
        .ad_blocks(ad_blocks), .msg_blocks(msg_blocks), .sq_blocks(sq_blocks),
        .perm_done(perm_done), .perm_start(perm_start), .perm_rounds(perm_rounds),
        .phase(phase), .key_xor_init(key_xor_init), .key_xor_final(key_xor_final),
        .dsep(dsep), .sq_valid(sq_valid), .blk_idx(blk_idx), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    function automatic int ev(input int t, input int r, input int p, input int b);
        return (t << 12) | (r << 8) | (p << 4) | b;
    endfunction

    // Reference sequence of events for one operation.
    function automatic void build_expected(input int mode, input int ad, input int msg, input int sq);
        int m, n, pb;
        bit aead;
        m    = (msg == 0) ? 1 : msg;
        n    = (mode == 3) ? 4 : ((sq == 0) ? 1 : sq);
        aead = (mode == 1) || (mode == 2);
        pb   = aead ? 6 : 12;
        exp_q.delete();
        exp_q.push_back(ev(EV_PERM, 12, 1, 0));
        if (aead) exp_q.push_back(ev(EV_KXI, 0, 0, 0));
        if (aead || mode == 5) begin
            for (int i = 0; i < ad; i++) exp_q.push_back(ev(EV_PERM, pb, 2, i));
            exp_q.push_back(ev(EV_DSEP, 0, 0, 0));
        end
        if (aead) begin
            for (int i = 0; i < m - 1; i++) exp_q.push_back(ev(EV_PERM, 6, 3, i));
            exp_q.push_back(ev(EV_KXF, 0, 0, 0));
            exp_q.push_back(ev(EV_PERM, 12, 4, 0));
        end else begin
            for (int i = 0; i < m; i++) exp_q.push_back(ev(EV_PERM, 12, 3, i));
            for (int i = 0; i < n; i++) begin
                exp_q.push_back(ev(EV_SQV, 0, 5, i));
                if (i < n - 1) exp_q.push_back(ev(EV_PERM, 12, 5, i));
            end
        end
        exp_q.push_back(ev(EV_DONE, 0, 6, 0));
    endfunction

    task automatic run_op(input logic [2:0] mode, input logic [3:0] ad, input logic [3:0] msg,
                          input logic [3:0] sq, input int lat, input bit inject, input string name);
        int  cnt = 0;
        int  obs[$];
        int  expv;
        bit  fin = 0, overlap = 0, busy_drop = 0, err_seen = 0;
        build_expected(int'(mode), int'(ad), int'(msg), int'(sq));
        @(negedge clk);
        start = 1'b1; operation_mode = mode; ad_blocks = ad; msg_blocks = msg; sq_blocks = sq;
        @(negedge clk);
        start = 1'b0; operation_mode = 3'd0; ad_blocks = ~ad; msg_blocks = ~msg; sq_blocks = ~sq;
        n_checks++;
        if (perm_start !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s start_latency: perm_start=%b busy=%b, expected 1 1", name, perm_start, busy);
        end
        for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
            if (cyc > 0) @(negedge clk);
            perm_done = 1'b0;
            start     = 1'b0;
            if (perm_start && (key_xor_init || key_xor_final || dsep || sq_valid)) overlap = 1;
            if (busy !== 1'b1) busy_drop = 1;
            if (err) err_seen = 1;
            obs.delete();
            if (perm_start)    obs.push_back(ev(EV_PERM, int'(perm_rounds), int'(phase), int'(blk_idx)));
            if (key_xor_init)  obs.push_back(ev(EV_KXI, 0, 0, 0));
            if (dsep)          obs.push_back(ev(EV_DSEP, 0, 0, 0));
            if (key_xor_final) obs.push_back(ev(EV_KXF, 0, 0, 0));
            if (sq_valid)      obs.push_back(ev(EV_SQV, 0, int'(phase), int'(blk_idx)));
            if (done)          obs.push_back(ev(EV_DONE, 0, int'(phase), int'(blk_idx)));
            foreach (obs[i]) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL %s event: got %h, expected nothing more", name, obs[i]);
                end else begin
                    expv = exp_q.pop_front();
                    if (obs[i] !== expv) begin
                        n_fail++;
                        $display("FAIL %s event: got %h, expected %h", name, obs[i], expv);
                    end
                end
                if ((obs[i] >> 12) == EV_DONE) fin = 1;
            end
            if (perm_start) cnt = lat;
            else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) perm_done = 1'b1;
            end
            if (inject && cyc == 4) begin
                start = 1'b1; operation_mode = 3'd3;
            end
        end
        perm_done = 1'b0;
        start     = 1'b0;
        n_checks++;
        if (!fin || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s completion: done_seen=%0d left=%0d, expected 1 0", name, fin, exp_q.size());
        end
        n_checks++;
        if (overlap || busy_drop || err_seen) begin
            n_fail++;
            $display("FAIL %s strobes: overlap=%0d busy_drop=%0d err=%0d, expected 0 0 0",
                     name, overlap, busy_drop, err_seen);
        end
        @(negedge clk);
        n_checks++;
        if (phase !== 3'd0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s return_idle: phase=%0d busy=%b done=%b, expected 0 0 0", name, phase, busy, done);
        end
    endtask

    task automatic test_reset();
        spi_rst_n = 1'b0; start = 1'b0; operation_mode = 3'd0; perm_done = 1'b0;
        ad_blocks = 4'd0; msg_blocks = 4'd0; sq_blocks = 4'd0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({perm_start, key_xor_init, key_xor_final, dsep, sq_valid, busy, done, err} !== 8'd0 ||
            phase !== 3'd0 || blk_idx !== 4'd0 || perm_rounds !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_state: phase=%0d busy=%b perm_start=%b rounds=%0d, expected all 0",
                     phase, busy, perm_start, perm_rounds);
        end
        spi_rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (phase !== 3'd0 || busy !== 1'b0 || perm_start !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: phase=%0d busy=%b perm_start=%b, expected 0 0 0", phase, busy, perm_start);
        end
    endtask

    task automatic test_bad_mode();
        logic [2:0] bad_modes[3] = '{3'd0, 3'd6, 3'd7};
        bit launched;
        foreach (bad_modes[k]) begin
            @(negedge clk);
            start = 1'b1; operation_mode = bad_modes[k]; msg_blocks = 4'd2;
            @(negedge clk);
            start = 1'b0;
            n_checks++;
            if (err !== 1'b1 || perm_start !== 1'b0 || busy !== 1'b0 || phase !== 3'd0) begin
                n_fail++;
                $display("FAIL bad_mode%0d: err=%b perm_start=%b busy=%b phase=%0d, expected 1 0 0 0",
                         bad_modes[k], err, perm_start, busy, phase);
            end
            launched = 0;
            @(negedge clk);
            n_checks++;
            if (err !== 1'b0) begin
                n_fail++;
                $display("FAIL bad_mode%0d_err_width: err=%b, expected 0", bad_modes[k], err);
            end
            repeat (3) begin
                if (perm_start || busy) launched = 1;
                @(negedge clk);
            end
            n_checks++;
            if (launched) begin
                n_fail++;
                $display("FAIL bad_mode%0d_quiet: launched=%0d, expected 0", bad_modes[k], launched);
            end
        end
    endtask

    task automatic test_reset_mid();
        int cnt = 0;
        bit hit = 0, bad = 0;
        @(negedge clk);
        start = 1'b1; operation_mode = 3'd1; ad_blocks = 4'd0; msg_blocks = 4'd4; sq_blocks = 4'd0;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 500 && !hit; cyc++) begin
            if (cyc > 0) @(negedge clk);
            perm_done = 1'b0;
            if (perm_start && phase == 3'd3) hit = 1;
            else if (perm_start) cnt = 3;
            else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) perm_done = 1'b1;
            end
        end
        perm_done = 1'b0;
        n_checks++;
        if (!hit) begin
            n_fail++;
            $display("FAIL reset_mid_reach_msg: reached=%0d, expected 1", hit);
        end
        @(negedge clk);
        spi_rst_n = 1'b0;
        #1;
        n_checks++;
        if ({perm_start, key_xor_init, key_xor_final, dsep, sq_valid, busy, done, err} !== 8'd0 ||
            phase !== 3'd0 || blk_idx !== 4'd0 || perm_rounds !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_mid_clear: phase=%0d busy=%b blk=%0d rounds=%0d, expected all 0",
                     phase, busy, blk_idx, perm_rounds);
        end
        @(negedge clk);
        @(negedge clk);
        spi_rst_n = 1'b1;
        @(negedge clk);
        perm_done = 1'b1;
        @(negedge clk);
        perm_done = 1'b0;
        repeat (8) begin
            if (perm_start || busy || done || err || phase != 3'd0) bad = 1;
            @(negedge clk);
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL reset_mid_stale_done: activity=%0d, expected 0", bad);
        end
        run_op(3'd3, 4'd0, 4'd1, 4'd0, 2, 1'b0, "hash_after_reset");
    endtask

    task automatic test_encrypt();
        run_op(3'd1, 4'd2, 4'd3, 4'd0, 5, 1'b0, "encrypt_ad2_msg3");
    endtask

    task automatic test_hash();
        run_op(3'd3, 4'd0, 4'd1, 4'd0, 5, 1'b0, "hash_msg1");
    endtask

    task automatic test_decrypt_empty();
        run_op(3'd2, 4'd0, 4'd0, 4'd0, 3, 1'b0, "decrypt_ad0_msg0");
    endtask

    task automatic test_start_while_busy();
        run_op(3'd1, 4'd1, 4'd2, 4'd0, 4, 1'b1, "encrypt_start_while_busy");
    endtask

    task automatic test_cxof();
        run_op(3'd5, 4'd15, 4'd1, 4'd0, 2, 1'b0, "cxof_ad15_sq0");
    endtask

    task automatic test_back_to_back();
        run_op(3'd4, 4'd0, 4'd2, 4'd3, 1, 1'b0, "xof_msg2_sq3");
        run_op(3'd2, 4'd1, 4'd2, 4'd0, 1, 1'b0, "decrypt_ad1_msg2");
        run_op(3'd5, 4'd0, 4'd0, 4'd2, 1, 1'b0, "cxof_ad0_sq2");
    endtask

    initial begin
        test_reset();
        test_encrypt();
        test_hash();
        test_decrypt_empty();
        test_bad_mode();
        test_start_while_busy();
        test_reset_mid();
        test_cxof();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
